// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants and types for the sprite renderer
package sprite_pkg;

  localparam int SPRITE_DIM = 16;
  localparam int BPP        = 2;
  localparam int ROW_BITS   = SPRITE_DIM * BPP;

  localparam int MISC_EN       = 0;
  localparam int MISC_MIRROR_X = 1;
  localparam int MISC_MIRROR_Y = 2;
  localparam int MISC_SCALE_LO = 3;
  localparam int MISC_SCALE_HI = 4;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    LOAD
  } fetch_state_e;

  typedef logic [5:0] rgb222_t;

endpackage

// File: rtl/sprite_rom.sv
// rtl/sprite_rom.sv - 16x32 sprite bitmap, 2 bpp, one-cycle registered read
module sprite_rom
  import sprite_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [3:0]          addr_i,
  output logic [ROW_BITS-1:0] data_o
);

  logic [ROW_BITS-1:0] data_q, data_d;

  // Pixel c of a row lives in bits [2c+1:2c]; only row 0 uses palette index 1
  always_comb begin
    data_d = '0;
    case (addr_i)
      4'd0:  data_d = 32'h0000_0001;
      4'd1:  data_d = 32'h0000_0F0A;
      4'd2:  data_d = 32'h0000_F0A0;
      4'd3:  data_d = 32'h000F_0A00;
      4'd4:  data_d = 32'h00F0_A000;
      4'd5:  data_d = 32'h0F0A_0000;
      4'd6:  data_d = 32'hF0A0_0000;
      4'd7:  data_d = 32'h0A00_000F;
      4'd8:  data_d = 32'hA000_00F0;
      4'd9:  data_d = 32'h3C3C_3C3C;
      4'd10: data_d = 32'hC3C3_C3C3;
      4'd11: data_d = 32'h8282_8282;
      4'd12: data_d = 32'h2828_2828;
      4'd13: data_d = 32'hEEEE_EEEE;
      4'd14: data_d = 32'hBBBB_BBBB;
      4'd15: data_d = 32'hC000_0000;
      default: data_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) data_q <= '0;
    else         data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/sprite_renderer.sv
// rtl/sprite_renderer.sv - one 16x16 2-bpp sprite over a background, RGB222 out, latency 2
// Optional integer scaling of the sprite is enabled by defining SPRITE_SCALE_EN.
module sprite_renderer
  import sprite_pkg::*;
#(
  parameter int COORD_SHIFT = 1,
  parameter int H_BITS      = 10,
  parameter int V_BITS      = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [5:0]        color1_i,
  input  logic [5:0]        color2_i,
  input  logic [5:0]        color3_i,
  input  logic [5:0]        color4_i,
  input  logic [7:0]        sprite_x_i,
  input  logic [7:0]        sprite_y_i,
  input  logic [4:0]        misc_i,
  input  logic [H_BITS-1:0] hpos_i,
  input  logic [V_BITS-1:0] vpos_i,
  input  logic              de_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic              frame_start_i,
  input  logic              line_start_i,
  output logic [5:0]        rgb_o,
  output logic              de_o,
  output logic              hsync_o,
  output logic              vsync_o
);

  rgb222_t     c1_q, c1_d, c2_q, c2_d, c3_q, c3_d, c4_q, c4_d;
  logic [7:0]  sx_q, sx_d, sy_q, sy_d;
  logic [4:0]  misc_q, misc_d;

  fetch_state_e        state_q, state_d;
  logic                hit_q, hit_d, line_hit_q, line_hit_d;
  logic [ROW_BITS-1:0] line_buf_q, line_buf_d, rom_data;
  logic [3:0]          rom_addr;
  logic signed [V_BITS:0] row_diff, row;
  logic                row_hit;

  logic signed [H_BITS:0] col_diff, col;
  logic [3:0]  col_c;
  logic        in_q, in_d, de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [1:0]  idx_q, idx_d;
  rgb222_t     rgb_q, rgb_d;
  logic        de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d;

  // Config only moves at frame boundaries so a frame is never torn
  always_comb begin
    c1_d = c1_q; c2_d = c2_q; c3_d = c3_q; c4_d = c4_q;
    sx_d = sx_q; sy_d = sy_q; misc_d = misc_q;
    if (frame_start_i) begin
      c1_d = color1_i; c2_d = color2_i; c3_d = color3_i; c4_d = color4_i;
      sx_d = sprite_x_i; sy_d = sprite_y_i; misc_d = misc_i;
    end
  end

  assign row_diff = $signed({1'b0, vpos_i}) - $signed((V_BITS+1)'({sy_q, {COORD_SHIFT{1'b0}}}));
  assign col_diff = $signed({1'b0, hpos_i}) - $signed((H_BITS+1)'({sx_q, {COORD_SHIFT{1'b0}}}));

`ifdef SPRITE_SCALE_EN
  assign row = row_diff >>> misc_q[MISC_SCALE_HI:MISC_SCALE_LO];
  assign col = col_diff >>> misc_q[MISC_SCALE_HI:MISC_SCALE_LO];
`else
  logic unused_scale;
  assign unused_scale = ^misc_q[MISC_SCALE_HI:MISC_SCALE_LO];
  assign row = row_diff;
  assign col = col_diff;
`endif

  // Negative offsets read as huge unsigned values, so one compare covers both bounds
  assign row_hit  = misc_q[MISC_EN] && ($unsigned(row) < (V_BITS+1)'(SPRITE_DIM));
  assign rom_addr = misc_q[MISC_MIRROR_Y] ? ~row[3:0] : row[3:0];

  sprite_rom u_rom (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  always_comb begin
    state_d    = state_q;
    hit_d      = hit_q;
    line_hit_d = line_hit_q;
    line_buf_d = line_buf_q;
    case (state_q)
      IDLE: if (line_start_i) state_d = ADDR;
      ADDR: begin
        hit_d   = row_hit;
        state_d = line_start_i ? ADDR : LOAD;
      end
      LOAD: begin
        if (line_start_i) begin
          state_d = ADDR;
        end else begin
          line_buf_d = hit_q ? rom_data : '0;
          line_hit_d = hit_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    col_c = misc_q[MISC_MIRROR_X] ? ~col[3:0] : col[3:0];
    in_d  = line_hit_q && ($unsigned(col) < (H_BITS+1)'(SPRITE_DIM));
    idx_d = line_buf_q[{col_c, 1'b0} +: BPP];
    de1_d = de_i;
    hs1_d = hsync_i;
    vs1_d = vsync_i;
  end

  always_comb begin
    rgb_d = '0;
    if (de1_q) begin
      case (in_q ? idx_q : 2'd0)
        2'd1:    rgb_d = c2_q;
        2'd2:    rgb_d = c3_q;
        2'd3:    rgb_d = c4_q;
        default: rgb_d = c1_q;
      endcase
    end
    de2_d = de1_q;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c1_q <= '0; c2_q <= '0; c3_q <= '0; c4_q <= '0;
      sx_q <= '0; sy_q <= '0; misc_q <= '0;
      state_q <= IDLE; hit_q <= 1'b0; line_hit_q <= 1'b0; line_buf_q <= '0;
      in_q <= 1'b0; idx_q <= '0; de1_q <= 1'b0; hs1_q <= 1'b0; vs1_q <= 1'b0;
      rgb_q <= '0; de2_q <= 1'b0; hs2_q <= 1'b0; vs2_q <= 1'b0;
    end else begin
      c1_q <= c1_d; c2_q <= c2_d; c3_q <= c3_d; c4_q <= c4_d;
      sx_q <= sx_d; sy_q <= sy_d; misc_q <= misc_d;
      state_q <= state_d; hit_q <= hit_d; line_hit_q <= line_hit_d; line_buf_q <= line_buf_d;
      in_q <= in_d; idx_q <= idx_d; de1_q <= de1_d; hs1_q <= hs1_d; vs1_q <= vs1_d;
      rgb_q <= rgb_d; de2_q <= de2_d; hs2_q <= hs2_d; vs2_q <= vs2_d;
    end
  end

  assign rgb_o   = rgb_q;
  assign de_o    = de2_q;
  assign hsync_o = hs2_q;
  assign vsync_o = vs2_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// tb/tb_sprite_renderer.sv - vector table, corner sequences and random frames against a pixel-space model
module tb_sprite_renderer;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [5:0] color1_i, color2_i, color3_i, color4_i;
  logic [7:0] sprite_x_i, sprite_y_i;
  logic [4:0] misc_i;
  logic [9:0] hpos_i, vpos_i;
  logic       de_i, hsync_i, vsync_i, frame_start_i, line_start_i;
  logic [5:0] rgb_o;
  logic       de_o, hsync_o, vsync_o;

  always #5 clk_i = ~clk_i;

  sprite_renderer dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .color1_i(color1_i), .color2_i(color2_i), .color3_i(color3_i), .color4_i(color4_i),
    .sprite_x_i(sprite_x_i), .sprite_y_i(sprite_y_i), .misc_i(misc_i),
    .hpos_i(hpos_i), .vpos_i(vpos_i), .de_i(de_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .frame_start_i(frame_start_i), .line_start_i(line_start_i),
    .rgb_o(rgb_o), .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  logic [31:0] bm [16] = '{
    32'h0000_0001, 32'h0000_0F0A, 32'h0000_F0A0, 32'h000F_0A00,
    32'h00F0_A000, 32'h0F0A_0000, 32'hF0A0_0000, 32'h0A00_000F,
    32'hA000_00F0, 32'h3C3C_3C3C, 32'hC3C3_C3C3, 32'h8282_8282,
    32'h2828_2828, 32'hEEEE_EEEE, 32'hBBBB_BBBB, 32'hC000_0000};

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] m_col [4];
  logic [7:0] m_x, m_y;
  logic [4:0] m_misc;

  logic [8:0] pe [2];
  int         ph [2];
  int         pv [2];
  logic [5:0] cap [20][640];
  logic       dbl_ls = 1'b0;

  typedef struct {
    string      name;
    logic [4:0] misc;
    logic [7:0] x;
    logic [7:0] y;
    int         lines;
    int         width;
    int         h;
    int         v;
    logic [5:0] exp;
  } vec_t;

  vec_t vt [15];

  function automatic logic [5:0] model_rgb(input int h, input int v);
    int s, dx, dy, r, c, size;
    logic [31:0] row;
    logic [1:0] idx;
`ifdef SPRITE_SCALE_EN
    s = int'(m_misc[4:3]);
`else
    s = 0;
`endif
    size = 16 << s;
    dx = h - int'(m_x) * 2;
    dy = v - int'(m_y) * 2;
    if (m_misc[0] && dx >= 0 && dx < size && dy >= 0 && dy < size) begin
      r = dy / (1 << s);
      c = dx / (1 << s);
      if (m_misc[2]) r = 15 - r;
      if (m_misc[1]) c = 15 - c;
      row = bm[r];
      idx = row[2*c +: 2];
      if (idx != 2'd0) return m_col[idx];
    end
    return m_col[0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_col[i] = '0;
    m_x = '0; m_y = '0; m_misc = '0;
    for (int i = 0; i < 2; i++) begin pe[i] = '0; ph[i] = -1; pv[i] = -1; end
  endtask

  task automatic drive(input int h, input int v, input logic de, input logic hs,
                       input logic vs, input logic fs, input logic ls);
    logic [8:0] got;
    @(posedge clk_i); #1;
    got = {vsync_o, hsync_o, de_o, rgb_o};
    n_tests++;
    if (got !== pe[1]) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL pixel h=%0d v=%0d got=%h exp=%h", ph[1], pv[1], got, pe[1]);
    end
    if (pe[1][6] && pv[1] >= 0 && pv[1] < 20 && ph[1] >= 0 && ph[1] < 640) cap[pv[1]][ph[1]] = rgb_o;
    pe[1] = pe[0]; ph[1] = ph[0]; pv[1] = pv[0];
    pe[0] = {vs, hs, de, de ? model_rgb(h, v) : 6'h00};
    ph[0] = h; pv[0] = v;
    hpos_i = 10'(h); vpos_i = 10'(v);
    de_i = de; hsync_i = hs; vsync_i = vs; frame_start_i = fs; line_start_i = ls;
    if (fs) begin
      m_col[0] = color1_i; m_col[1] = color2_i; m_col[2] = color3_i; m_col[3] = color4_i;
      m_x = sprite_x_i; m_y = sprite_y_i; m_misc = misc_i;
    end
  endtask

  task automatic run_frame(input int lines, input int width, input logic fs_with_ls,
                           input int mid_line, input logic [7:0] mid_x);
    if (!fs_with_ls)
      for (int k = 0; k < 8; k++) drive(width + k, lines, 1'b0, 1'b0, 1'b1, k == 2, 1'b0);
    for (int l = 0; l < lines; l++) begin
      if (l == mid_line) sprite_x_i = mid_x;
      for (int k = 0; k < 12; k++)
        drive(width + k, l, 1'b0, k >= 4 && k < 8, 1'b0, fs_with_ls && l == 0 && k == 2,
              k == 2 || (dbl_ls && k == 3));
      for (int h = 0; h < width; h++) drive(h, l, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    drive(width, lines, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(width + 1, lines, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_cfg(input logic [4:0] misc, input logic [7:0] x, input logic [7:0] y);
    misc_i = misc; sprite_x_i = x; sprite_y_i = y;
  endtask

  task automatic table_colors();
    color1_i = 6'h03; color2_i = 6'h30; color3_i = 6'h0C; color4_i = 6'h3F;
  endtask

  initial begin
    logic [5:0] s77, s11;
`ifdef SPRITE_SCALE_EN
    s77 = 6'h30; s11 = 6'h30;
`else
    s77 = 6'h03; s11 = 6'h0C;
`endif
    vt[0]  = '{"bg_a",      5'd0,      8'd0,   8'd0, 4,  64,  5,   3,  6'h03};
    vt[1]  = '{"bg_b",      5'd0,      8'd0,   8'd0, 4,  64,  63,  0,  6'h03};
    vt[2]  = '{"px00",      5'd1,      8'd0,   8'd0, 4,  64,  0,   0,  6'h30};
    vt[3]  = '{"px10",      5'd1,      8'd0,   8'd0, 4,  64,  1,   0,  6'h03};
    vt[4]  = '{"mirx_15",   5'd3,      8'd0,   8'd0, 4,  64,  15,  0,  6'h30};
    vt[5]  = '{"mirx_0",    5'd3,      8'd0,   8'd0, 4,  64,  0,   0,  6'h03};
    vt[6]  = '{"miry_0_15", 5'd5,      8'd0,   8'd0, 16, 64,  0,   15, 6'h30};
    vt[7]  = '{"miry_0_0",  5'd5,      8'd0,   8'd0, 16, 64,  0,   0,  6'h03};
    vt[8]  = '{"miry_15_0", 5'd5,      8'd0,   8'd0, 16, 64,  15,  0,  6'h3F};
    vt[9]  = '{"edge_510",  5'd1,      8'hFF,  8'd0, 2,  640, 510, 0,  6'h30};
    vt[10] = '{"edge_514",  5'd1,      8'hFF,  8'd0, 2,  640, 514, 1,  6'h3F};
    vt[11] = '{"edge_510b", 5'd1,      8'hFF,  8'd0, 2,  640, 510, 1,  6'h0C};
    vt[12] = '{"edge_525",  5'd3,      8'hFF,  8'd0, 2,  640, 525, 0,  6'h30};
    vt[13] = '{"scale_77",  5'b11001,  8'd0,   8'd0, 10, 64,  7,   7,  s77};
    vt[14] = '{"scale_11",  5'b11001,  8'd0,   8'd0, 10, 64,  1,   1,  s11};

    model_reset();
    rst_ni = 1'b0;
    table_colors();
    set_cfg(5'd0, 8'd0, 8'd0);
    hpos_i = '0; vpos_i = '0; frame_start_i = 1'b0; line_start_i = 1'b0;
    de_i = 1'b1; hsync_i = 1'b1; vsync_i = 1'b1;
    #12;
    chk("reset_rgb", 32'(rgb_o), 32'h0);
    chk("reset_de", 32'(de_o), 32'h0);
    chk("reset_hs", 32'(hsync_o), 32'h0);
    chk("reset_vs", 32'(vsync_o), 32'h0);
    de_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
    #10 rst_ni = 1'b1;

    for (int i = 0; i < 15; i++) begin
      set_cfg(vt[i].misc, vt[i].x, vt[i].y);
      run_frame(vt[i].lines, vt[i].width, 1'b0, -1, 8'd0);
      chk(vt[i].name, 32'(cap[vt[i].v][vt[i].h]), 32'(vt[i].exp));
    end

    set_cfg(5'd1, 8'd5, 8'd0);
    run_frame(6, 64, 1'b0, 2, 8'd10);
    chk("xchg_old_r0", 32'(cap[0][10]), 32'h30);
    chk("xchg_old_r3", 32'(cap[3][14]), 32'h0C);
    run_frame(6, 64, 1'b0, -1, 8'd0);
    chk("xchg_new_r0", 32'(cap[0][20]), 32'h30);
    chk("xchg_new_r3", 32'(cap[3][24]), 32'h0C);
    chk("xchg_new_old", 32'(cap[3][14]), 32'h03);

    set_cfg(5'd0, 8'd0, 8'd0);
    run_frame(2, 64, 1'b0, -1, 8'd0);
    set_cfg(5'd1, 8'd0, 8'd0);
    run_frame(2, 64, 1'b1, -1, 8'd0);
    chk("fs_ls_same", 32'(cap[0][0]), 32'h30);

    for (int f = 0; f < 6; f++) begin
      color1_i = 6'($urandom); color2_i = 6'($urandom);
      color3_i = 6'($urandom); color4_i = 6'($urandom);
      set_cfg(5'($urandom), 8'($urandom_range(0, 40)), 8'($urandom_range(0, 12)));
      dbl_ls = 1'($urandom);
      run_frame(20, 64, 1'b0, -1, 8'd0);
    end
    dbl_ls = 1'b0;

    table_colors();
    set_cfg(5'd1, 8'd0, 8'd0);
    run_frame(1, 64, 1'b0, -1, 8'd0);
    for (int h = 0; h < 6; h++) drive(h, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_ni = 1'b0;
    de_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0; frame_start_i = 1'b0; line_start_i = 1'b0;
    #1;
    chk("midrst_rgb", 32'(rgb_o), 32'h0);
    chk("midrst_de", 32'(de_o), 32'h0);
    @(posedge clk_i);
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    model_reset();
    for (int k = 0; k < 12; k++) drive(64 + k, 0, 1'b0, 1'b0, 1'b0, 1'b0, k == 2);
    for (int h = 0; h < 20; h++) drive(h, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(64, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(65, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("postrst_dark", 32'(cap[0][0]), 32'h0);
    run_frame(2, 64, 1'b0, -1, 8'd0);
    chk("postrst_resume", 32'(cap[0][0]), 32'h30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
